// File: rtl/pmod_uart_lite.sv
`default_nettype none
// ============================================================================
// Module   : pmod_uart_lite
// Brief    : AXI4-Lite 8N1 UART with RX/TX FIFOs, baud divisor and level IRQ.
//            Optional internal loopback enabled by macro PMOD_UART_LOOPBACK_EN.
// Revision : 1.0
// ============================================================================

module pmod_uart_lite_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module pmod_uart_lite #(
    parameter int DEFAULT_DIV = 868,
    parameter int RX_DEPTH    = 16,
    parameter int TX_DEPTH    = 16
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic [3:0]  s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [3:0]  s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        uart_txd,
    input  logic        uart_rxd,
    output logic        uart_interrupt
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam logic [15:0] MIN_DIV   = 16'd16;
    localparam logic [15:0] RESET_DIV = 16'(DEFAULT_DIV);

    logic [15:0] divisor;
    logic        rx_ie, tx_ie, loopback, overrun;
    logic        wr_fire, rd_fire;
    logic [1:0]  wr_sel, rd_sel;
    logic [15:0] div_wr;
    logic [31:0] rd_mux;
    logic        unused_bits;

    logic       rx_empty, rx_full, rx_push, rx_pop;
    logic       tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0] rx_dout, tx_dout;

    logic        tx_line, txd_next;
    uart_state_t tx_state, tx_next;
    logic [15:0] tx_cnt, tx_div;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_bit;
    logic        tx_tick;

    logic [1:0]  rxd_sync;
    logic        rx_in, rx_prev;
    uart_state_t rx_state, rx_next;
    logic [15:0] rx_cnt, rx_div;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_bit;
    logic        rx_tick;

    assign s_axi_wready = s_axi_awready;
    assign s_axi_bresp  = 2'b00;
    assign s_axi_rresp  = 2'b00;
    assign wr_fire = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
    assign rd_fire = s_axi_arready & s_axi_arvalid;
    assign wr_sel  = s_axi_awaddr[3:2];
    assign rd_sel  = s_axi_araddr[3:2];

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_awready <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'h0;
        end else begin
            s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
            if (wr_fire)           s_axi_bvalid <= 1'b1;
            else if (s_axi_bready) s_axi_bvalid <= 1'b0;
            s_axi_arready <= s_axi_arvalid & ~s_axi_rvalid & ~s_axi_arready;
            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_mux;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        case (rd_sel)
            2'd0:    rd_mux = rx_empty ? 32'h0 : {24'h0, rx_dout};
            2'd2:    rd_mux = {27'h0, overrun, tx_full, tx_empty, rx_full, rx_empty};
            2'd3:    rd_mux = {13'h0, loopback, tx_ie, rx_ie, divisor};
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        div_wr = divisor;
        if (s_axi_wstrb[0]) div_wr[7:0]  = s_axi_wdata[7:0];
        if (s_axi_wstrb[1]) div_wr[15:8] = s_axi_wdata[15:8];
    end

    assign tx_push = wr_fire && (wr_sel == 2'd1) && s_axi_wstrb[0];
    assign rx_pop  = rd_fire && (rd_sel == 2'd0);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            divisor        <= RESET_DIV;
            rx_ie          <= 1'b0;
            tx_ie          <= 1'b0;
            overrun        <= 1'b0;
            uart_interrupt <= 1'b0;
        end else begin
            if (wr_fire && wr_sel == 2'd3) begin
                divisor <= (div_wr < MIN_DIV) ? MIN_DIV : div_wr;
                if (s_axi_wstrb[2]) begin
                    rx_ie <= s_axi_wdata[16];
                    tx_ie <= s_axi_wdata[17];
                end
            end
            // A new overrun wins over a simultaneous clearing STATUS read.
            if (rx_push && rx_full)                   overrun <= 1'b1;
            else if (rd_fire && rd_sel == 2'd2)       overrun <= 1'b0;
            uart_interrupt <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | overrun;
        end
    end

`ifdef PMOD_UART_LOOPBACK_EN
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)                                   loopback <= 1'b0;
        else if (wr_fire && wr_sel == 2'd3 && s_axi_wstrb[2]) loopback <= s_axi_wdata[18];
    end
    assign rx_in       = loopback ? tx_line : rxd_sync[1];
    assign txd_next    = loopback ? 1'b1 : tx_line;
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:19], s_axi_wstrb[3]};
`else
    assign loopback    = 1'b0;
    assign rx_in       = rxd_sync[1];
    assign txd_next    = tx_line;
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:18], s_axi_wstrb[3]};
`endif

    pmod_uart_lite_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .push(tx_push), .wdata(s_axi_wdata[7:0]),
        .pop(tx_pop), .rdata(tx_dout), .empty(tx_empty), .full(tx_full)
    );

    pmod_uart_lite_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .push(rx_push), .wdata(rx_shift),
        .pop(rx_pop), .rdata(rx_dout), .empty(rx_empty), .full(rx_full)
    );

    assign tx_line = (tx_state == ST_START) ? 1'b0 : (tx_state == ST_DATA) ? tx_shift[0] : 1'b1;
    assign tx_tick = (tx_cnt == tx_div - 16'd1);

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_next = ST_START;
                end
            end
            ST_START: if (tx_tick) tx_next = ST_DATA;
            ST_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = ST_STOP;
            ST_STOP:  if (tx_tick) tx_next = ST_IDLE;
            default:  tx_next = ST_IDLE;
        endcase
    end

    // Divisor is captured only when a frame starts, so mid-frame CTRL writes are deferred.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= 16'h0;
            tx_div   <= RESET_DIV;
            tx_shift <= 8'h0;
            tx_bit   <= 3'd0;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_next;
            uart_txd <= txd_next;
            if (tx_state == ST_IDLE) begin
                tx_cnt <= 16'h0;
                tx_bit <= 3'd0;
                if (tx_pop) begin
                    tx_shift <= tx_dout;
                    tx_div   <= divisor;
                end
            end else begin
                tx_cnt <= tx_tick ? 16'h0 : tx_cnt + 16'd1;
                if (tx_state == ST_DATA && tx_tick) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                end
            end
        end
    end

    assign rx_tick = (rx_cnt == rx_div - 16'd1);

    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        case (rx_state)
            ST_IDLE:  if (rx_prev && !rx_in) rx_next = ST_START;
            ST_START: if (rx_cnt == {1'b0, rx_div[15:1]}) rx_next = rx_in ? ST_IDLE : ST_DATA;
            ST_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = ST_STOP;
            ST_STOP: begin
                if (rx_tick) begin
                    rx_next = ST_IDLE;
                    rx_push = rx_in;
                end
            end
            default:  rx_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rxd_sync <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= 16'h0;
            rx_div   <= RESET_DIV;
            rx_shift <= 8'h0;
            rx_bit   <= 3'd0;
        end else begin
            rxd_sync <= {rxd_sync[0], uart_rxd};
            rx_prev  <= rx_in;
            rx_state <= rx_next;
            case (rx_state)
                ST_IDLE: begin
                    rx_cnt <= 16'h0;
                    rx_bit <= 3'd0;
                    rx_div <= divisor;
                end
                ST_START: rx_cnt <= (rx_next == ST_DATA) ? 16'h0 : rx_cnt + 16'd1;
                ST_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= 16'h0;
                        rx_shift <= {rx_in, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_cnt <= rx_cnt + 16'd1;
            endcase
        end
    end
endmodule

`default_nettype wire
